// File: rtl/id_ex_if.sv
// Decode-to-execute boundary bundle for the ID/EX register: decode-side fields in,
// execute/forwarding-side registered copies and hazard status out.
interface id_ex_if #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic             stall_i;
    logic             flush_i;
    logic             ID_valid_i;
    logic [XLEN-1:0]  ID_PC_i;
    logic [XLEN-1:0]  ID_RS1_data_i;
    logic [XLEN-1:0]  ID_RS2_data_i;
    logic [XLEN-1:0]  ID_Imm_i;
    logic [RA_W-1:0]  ID_RS1_i;
    logic [RA_W-1:0]  ID_RS2_i;
    logic [RA_W-1:0]  ID_RD_i;
    logic             ID_uses_RS1_i;
    logic             ID_uses_RS2_i;
    logic [8:0]       ID_ctrl_i;
    logic [3:0]       ID_funct_i;

    logic             EX_valid_o;
    logic [XLEN-1:0]  EX_PC_o;
    logic [XLEN-1:0]  EX_RS1_data_o;
    logic [XLEN-1:0]  EX_RS2_data_o;
    logic [XLEN-1:0]  EX_Imm_o;
    logic [RA_W-1:0]  EX_RS1_o;
    logic [RA_W-1:0]  EX_RS2_o;
    logic [RA_W-1:0]  EX_RD_o;
    logic [8:0]       EX_ctrl_o;
    logic [3:0]       EX_funct_o;
    logic             load_use_stall_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport master (
        output stall_i, flush_i, ID_valid_i, ID_PC_i, ID_RS1_data_i, ID_RS2_data_i,
               ID_Imm_i, ID_RS1_i, ID_RS2_i, ID_RD_i, ID_uses_RS1_i, ID_uses_RS2_i,
               ID_ctrl_i, ID_funct_i,
        input  EX_valid_o, EX_PC_o, EX_RS1_data_o, EX_RS2_data_o, EX_Imm_o,
               EX_RS1_o, EX_RS2_o, EX_RD_o, EX_ctrl_o, EX_funct_o,
               load_use_stall_o, bubble_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, ID_valid_i, ID_PC_i, ID_RS1_data_i, ID_RS2_data_i,
               ID_Imm_i, ID_RS1_i, ID_RS2_i, ID_RD_i, ID_uses_RS1_i, ID_uses_RS2_i,
               ID_ctrl_i, ID_funct_i,
        output EX_valid_o, EX_PC_o, EX_RS1_data_o, EX_RS2_data_o, EX_Imm_o,
               EX_RS1_o, EX_RS2_o, EX_RD_o, EX_ctrl_o, EX_funct_o,
               load_use_stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection: a load in EX whose
// destination is read by the ID instruction turns the next EX slot into a bubble.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic   clk_i,
    input  logic   rst_i,
    id_ex_if.slave bus
);
    localparam int MEMREAD_BIT = 7;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             vld_p1;
    logic [XLEN-1:0]  pc_p1;
    logic [XLEN-1:0]  rs1_data_p1;
    logic [XLEN-1:0]  rs2_data_p1;
    logic [XLEN-1:0]  imm_p1;
    logic [RA_W-1:0]  rs1_p1;
    logic [RA_W-1:0]  rs2_p1;
    logic [RA_W-1:0]  rd_p1;
    logic [8:0]       ctrl_p1;
    logic [3:0]       funct_p1;
    logic [CNT_W-1:0] bubble_cnt;
    logic             hazard;
    logic             load_use;

    always_comb begin
        hazard   = 1'b0;
        load_use = 1'b0;
        hazard = vld_p1 & ctrl_p1[MEMREAD_BIT] & (rd_p1 != '0) & bus.ID_valid_i &
                 ((bus.ID_uses_RS1_i & (bus.ID_RS1_i == rd_p1)) |
                  (bus.ID_uses_RS2_i & (bus.ID_RS2_i == rd_p1)));
        // A flushed ID instruction never executes, so it cannot be a consumer.
        load_use = hazard & ~bus.flush_i;
    end

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            ctrl_p1     <= '0;
            funct_p1    <= '0;
            bubble_cnt  <= '0;
        end else if (!bus.stall_i) begin
            pc_p1       <= bus.ID_PC_i;
            rs1_data_p1 <= bus.ID_RS1_data_i;
            rs2_data_p1 <= bus.ID_RS2_data_i;
            imm_p1      <= bus.ID_Imm_i;
            rs1_p1      <= bus.ID_RS1_i;
            rs2_p1      <= bus.ID_RS2_i;
            funct_p1    <= bus.ID_funct_i;
            if (bus.flush_i || load_use) begin
                vld_p1  <= 1'b0;
                ctrl_p1 <= '0;
                rd_p1   <= '0;
                if (load_use)
                    bubble_cnt <= sat_inc(bubble_cnt);
            end else begin
                vld_p1  <= bus.ID_valid_i;
                ctrl_p1 <= bus.ID_valid_i ? bus.ID_ctrl_i : 9'd0;
                rd_p1   <= bus.ID_RD_i;
            end
        end
    end

    assign bus.EX_valid_o       = vld_p1;
    assign bus.EX_PC_o          = pc_p1;
    assign bus.EX_RS1_data_o    = rs1_data_p1;
    assign bus.EX_RS2_data_o    = rs2_data_p1;
    assign bus.EX_Imm_o         = imm_p1;
    assign bus.EX_RS1_o         = rs1_p1;
    assign bus.EX_RS2_o         = rs2_p1;
    assign bus.EX_RD_o          = rd_p1;
    assign bus.EX_ctrl_o        = ctrl_p1;
    assign bus.EX_funct_o       = funct_p1;
    assign bus.load_use_stall_o = load_use;
    assign bus.bubble_cnt_o     = bubble_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written stall/reset/saturation
// sequences, then random traffic against a reference model of the EX slot.
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 12;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam logic [8:0] C_LW   = 9'h1B0;
    localparam logic [8:0] C_ADD  = 9'h102;
    localparam logic [8:0] C_ADDI = 9'h112;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_ex_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();
    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2;
        logic [8:0] ctrl;
        logic       stall, flush;
        logic       exp_lus, exp_vld;
        logic [8:0] exp_ctrl;
        logic [4:0] exp_rd, exp_rs1;
        int         exp_cnt;
    } vec_t;

    typedef struct {
        logic            vld;
        logic [XLEN-1:0] pc, d1, d2, imm;
        logic [RA_W-1:0] rs1, rs2, rd;
        logic [8:0]      ctrl;
        logic [3:0]      funct;
        int              cnt;
    } ex_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_id(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic [8:0] ctrl, input logic stall, input logic flush);
        bus.ID_valid_i    = valid;
        bus.ID_RS1_i      = rs1;
        bus.ID_RS2_i      = rs2;
        bus.ID_RD_i       = rd;
        bus.ID_uses_RS1_i = u1;
        bus.ID_uses_RS2_i = u2;
        bus.ID_ctrl_i     = ctrl;
        bus.stall_i       = stall;
        bus.flush_i       = flush;
        bus.ID_PC_i       = $urandom;
        bus.ID_RS1_data_i = $urandom;
        bus.ID_RS2_data_i = $urandom;
        bus.ID_Imm_i      = $urandom;
        bus.ID_funct_i    = 4'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    vec_t vecs[10];
    ex_t  m, mn;
    logic exp_lus;

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // valid rs1 rs2 rd u1 u2 ctrl stall flush | lus vld ctrl rd rs1 cnt
        vecs[0] = '{1, 1, 0, 5, 1, 0, C_LW,   0, 0, 0, 1, C_LW,   5, 1, 0};
        vecs[1] = '{1, 5, 1, 6, 1, 1, C_ADD,  0, 0, 1, 0, 9'h0,   0, 5, 1};
        vecs[2] = '{1, 5, 1, 6, 1, 1, C_ADD,  0, 0, 0, 1, C_ADD,  6, 5, 1};
        vecs[3] = '{1, 2, 0, 0, 1, 0, C_LW,   0, 0, 0, 1, C_LW,   0, 2, 1};
        vecs[4] = '{1, 0, 0, 8, 1, 1, C_ADD,  0, 0, 0, 1, C_ADD,  8, 0, 1};
        vecs[5] = '{1, 3, 0, 5, 1, 0, C_LW,   0, 0, 0, 1, C_LW,   5, 3, 1};
        vecs[6] = '{1, 6, 5, 7, 1, 0, C_ADDI, 0, 0, 0, 1, C_ADDI, 7, 6, 1};
        vecs[7] = '{1, 7, 0, 5, 1, 0, C_LW,   0, 0, 0, 1, C_LW,   5, 7, 1};
        vecs[8] = '{1, 5, 1, 6, 1, 1, C_ADD,  0, 1, 0, 0, 9'h0,   0, 5, 1};
        vecs[9] = '{0, 2, 0, 9, 1, 0, C_LW,   0, 0, 0, 0, 9'h0,   9, 2, 1};

        chk("reset_valid", bus.EX_valid_o, 0);
        chk("reset_cnt", bus.bubble_cnt_o, 0);
        for (int i = 0; i < 10; i++) begin
            set_id(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1,
                   vecs[i].u2, vecs[i].ctrl, vecs[i].stall, vecs[i].flush);
            #3;
            chk($sformatf("v%0d_lus", i), bus.load_use_stall_o, vecs[i].exp_lus);
            tick();
            chk($sformatf("v%0d_vld", i), bus.EX_valid_o, vecs[i].exp_vld);
            chk($sformatf("v%0d_ctrl", i), bus.EX_ctrl_o, vecs[i].exp_ctrl);
            chk($sformatf("v%0d_rd", i), bus.EX_RD_o, vecs[i].exp_rd);
            chk($sformatf("v%0d_rs1", i), bus.EX_RS1_o, vecs[i].exp_rs1);
            chk($sformatf("v%0d_cnt", i), bus.bubble_cnt_o, 64'(vecs[i].exp_cnt));
        end

        // Global stall for three cycles with a load-use pending.
        set_id(1, 1, 0, 5, 1, 0, C_LW, 0, 0);
        tick();
        set_id(1, 5, 1, 6, 1, 1, C_ADD, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ctrl", bus.EX_ctrl_o, C_LW);
            chk("hold_rd", bus.EX_RD_o, 5);
            chk("hold_vld", bus.EX_valid_o, 1);
            chk("hold_cnt", bus.bubble_cnt_o, 1);
        end
        bus.stall_i = 1'b0;
        #3;
        chk("release_lus", bus.load_use_stall_o, 1);
        tick();
        chk("release_bubble_vld", bus.EX_valid_o, 0);
        chk("release_bubble_ctrl", bus.EX_ctrl_o, 0);
        chk("release_cnt", bus.bubble_cnt_o, 2);
        tick();
        chk("release_consumer_ctrl", bus.EX_ctrl_o, C_ADD);
        chk("release_consumer_rd", bus.EX_RD_o, 6);

        // Reset mid-traffic, with a load in EX and a dependent instruction in ID.
        set_id(1, 1, 0, 5, 1, 0, C_LW, 0, 0);
        tick();
        set_id(1, 5, 5, 6, 1, 1, C_ADD, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        chk("rst_lus", bus.load_use_stall_o, 0);
        chk("rst_vld", bus.EX_valid_o, 0);
        chk("rst_ctrl", bus.EX_ctrl_o, 0);
        chk("rst_rd", bus.EX_RD_o, 0);
        chk("rst_pc", bus.EX_PC_o, 0);
        chk("rst_data1", bus.EX_RS1_data_o, 0);
        chk("rst_imm", bus.EX_Imm_o, 0);
        chk("rst_rs1", bus.EX_RS1_o, 0);
        chk("rst_funct", bus.EX_funct_o, 0);
        chk("rst_cnt", bus.bubble_cnt_o, 0);

        // Saturation: a self-dependent load chain stalls on every other edge.
        set_id(1, 5, 0, 5, 1, 0, C_LW, 0, 0);
        for (int i = 0; i < 2 * CMAX + 1; i++) tick();
        chk("sat_reach", bus.bubble_cnt_o, 64'(CMAX));
        #3;
        chk("sat_lus", bus.load_use_stall_o, 1);
        tick();
        chk("sat_hold", bus.bubble_cnt_o, 64'(CMAX));
        chk("sat_bubble", bus.EX_valid_o, 0);

        // Random traffic against the model.
        do_reset();
        m = '{default: '0};
        for (int c = 0; c < 3000; c++) begin
            logic r;
            r = ($urandom_range(0, 49) == 0);
            set_id(($urandom_range(0, 5) != 0), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 9'($urandom),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            rst = r;
            #3;
            exp_lus = m.vld && m.ctrl[7] && (m.rd != 0) && bus.ID_valid_i && !bus.flush_i &&
                      ((bus.ID_uses_RS1_i && bus.ID_RS1_i == m.rd) ||
                       (bus.ID_uses_RS2_i && bus.ID_RS2_i == m.rd));
            chk("rnd_lus", bus.load_use_stall_o, exp_lus);

            mn = m;
            if (r) begin
                mn = '{default: '0};
            end else if (!bus.stall_i) begin
                mn.pc = bus.ID_PC_i;   mn.d1 = bus.ID_RS1_data_i;
                mn.d2 = bus.ID_RS2_data_i; mn.imm = bus.ID_Imm_i;
                mn.rs1 = bus.ID_RS1_i; mn.rs2 = bus.ID_RS2_i; mn.funct = bus.ID_funct_i;
                if (bus.flush_i || exp_lus) begin
                    mn.vld = 0; mn.ctrl = 0; mn.rd = 0;
                    if (exp_lus && m.cnt < CMAX) mn.cnt = m.cnt + 1;
                end else begin
                    mn.vld  = bus.ID_valid_i;
                    mn.ctrl = bus.ID_valid_i ? bus.ID_ctrl_i : 9'd0;
                    mn.rd   = bus.ID_RD_i;
                end
            end
            m = mn;
            tick();
            rst = 1'b0;
            chk("rnd_vld", bus.EX_valid_o, m.vld);
            chk("rnd_ctrl", bus.EX_ctrl_o, m.ctrl);
            chk("rnd_rd", bus.EX_RD_o, m.rd);
            chk("rnd_cnt", bus.bubble_cnt_o, 64'(m.cnt));
            if (m.vld) begin
                chk("rnd_pc", bus.EX_PC_o, m.pc);
                chk("rnd_d1", bus.EX_RS1_data_o, m.d1);
                chk("rnd_d2", bus.EX_RS2_data_o, m.d2);
                chk("rnd_imm", bus.EX_Imm_o, m.imm);
                chk("rnd_rs1", bus.EX_RS1_o, m.rs1);
                chk("rnd_rs2", bus.EX_RS2_o, m.rs2);
                chk("rnd_funct", bus.EX_funct_o, m.funct);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
